// File: rtl/dm_cache_controller.sv
`timescale 1ns/1ps
// dm_cache_controller
//
// Sequences an 8-entry direct-mapped data cache between the CPU load/store
// unit and a multi-cycle data memory. One CPU access is in flight at a time.
// Loads that hit return the cached word. Loads that miss fetch the word from
// memory and fill the cache. Stores always go through to memory, and they
// update the cache only when the line is already present (no write-allocate).
// The controller also keeps saturating hit/miss statistics.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   cpu_req/we/addr/wdata  CPU access, accepted when cpu_req && cpu_ready
//   cpu_ready        high only while idle
//   cpu_done         one-cycle completion pulse
//   cpu_rdata        load result, held until the next completion
//   cache_addr       latched access address presented to the cache array
//   cache_wdata/we   fill/update data and one-cycle write strobe to the array
//   cache_hit/rdata  combinational lookup result from the array
//   mem_req/we/addr/wdata  memory request, held until mem_ack
//   mem_ack/rdata    memory completion and read data
//   hit_count/miss_count   saturating lookup statistics
module dm_cache_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [DATA_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_we,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        FILL,
        WRITE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  state;
    state_t                  state_next;
    logic                    we_q;
    logic                    hit_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    // The latched access drives both the cache array and the memory port.
    // Memory is word addressed, so the byte offset is dropped there only.
    assign cache_addr = addr_q;
    assign mem_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign mem_wdata  = wdata_q;

    // State register. Reset abandons whatever access was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Stores always take the WRITE path so memory stays
    // the authoritative copy; only a load miss needs a refill from memory.
    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    state_next = WRITE;
                end else if (cache_hit) begin
                    state_next = IDLE;
                end else begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                state_next = IDLE;
            end
            WRITE: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. cpu_done and cache_we default low
    // every cycle so that any assertion is exactly one cycle wide. For a
    // refill both strobes are raised on the edge entering FILL, so they are
    // visible during the FILL cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            hit_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_done    <= 1'b0;
            cpu_rdata   <= '0;
            cache_wdata <= '0;
            cache_we    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            cpu_done <= 1'b0;
            cache_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    hit_q <= cache_hit;
                    // Each counter sticks at all-ones independently.
                    if (cache_hit) begin
                        if (hit_count != CNT_MAX) begin
                            hit_count <= hit_count + CNT_WIDTH'(1);
                        end
                    end else begin
                        if (miss_count != CNT_MAX) begin
                            miss_count <= miss_count + CNT_WIDTH'(1);
                        end
                    end
                    if (we_q) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else if (cache_hit) begin
                        cpu_rdata <= cache_rdata;
                        cpu_done  <= 1'b1;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cpu_rdata   <= mem_rdata;
                        cache_wdata <= mem_rdata;
                        mem_req     <= 1'b0;
                        cache_we    <= 1'b1;
                        cpu_done    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        cpu_done <= 1'b1;
                        // A store miss leaves the cache untouched.
                        if (hit_q) begin
                            cache_wdata <= wdata_q;
                            cache_we    <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
`timescale 1ns/1ps
// tb_dm_cache_controller
//
// Drives dm_cache_controller against a behavioural cache array and a
// behavioural memory with configurable acknowledge delay. Expected results
// come from the access rules: a load returns the memory word, a load miss
// fills the line, a store writes memory and refreshes the line only on a
// hit, and the statistics count hits and misses with saturation.
module tb_dm_cache_controller;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [DW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic [DW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_we;
    logic          cache_hit;
    logic [DW-1:0] cache_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int total;
    int bad;

    dm_cache_controller #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_done    (cpu_done),
        .cpu_rdata   (cpu_rdata),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_we    (cache_we),
        .cache_hit   (cache_hit),
        .cache_rdata (cache_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-entry direct-mapped cache array: index is addr[4:2],
    // tag is everything above bit 4. hit_mask lets a test force a miss.
    logic          arr_valid [8];
    logic [DW-1:0] arr_tag   [8];
    logic [DW-1:0] arr_data  [8];
    logic          hit_mask;
    logic          arr_clear;

    always @(posedge clk) begin
        if (arr_clear) begin
            for (int i = 0; i < 8; i++) begin
                arr_valid[i] <= 1'b0;
                arr_tag[i]   <= '0;
                arr_data[i]  <= '0;
            end
        end else if (cache_we) begin
            arr_valid[cache_addr[4:2]] <= 1'b1;
            arr_tag[cache_addr[4:2]]   <= cache_addr >> 5;
            arr_data[cache_addr[4:2]]  <= cache_wdata;
        end
    end

    assign cache_hit   = hit_mask && arr_valid[cache_addr[4:2]] &&
                         (arr_tag[cache_addr[4:2]] == (cache_addr >> 5));
    assign cache_rdata = arr_data[cache_addr[4:2]];

    // Reference memory keyed by word address; unwritten words return a
    // fixed hash of the address so every read has a known value.
    logic [DW-1:0] mem_model [logic [DW-1:0]];

    function automatic logic [DW-1:0] memRead(input logic [DW-1:0] waddr);
        if (mem_model.exists(waddr)) begin
            return mem_model[waddr];
        end
        return (waddr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder: acknowledges after ack_wait cycles of mem_req and
    // logs what it saw. Drives 1 ns after the falling edge to stay clear of
    // the main sequence, which acts exactly on the falling edge.
    int            ack_wait;
    int            wait_cnt;
    logic          manual_ack;
    int            mem_rd_n = 0;
    int            mem_wr_n = 0;
    logic [DW-1:0] last_mem_addr = '0;
    logic [DW-1:0] last_mem_wdata = '0;
    logic          last_mem_we = 1'b0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            #1;
            mem_ack = 1'b0;
            if (manual_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_0BAD;
            end else if (mem_req && !rst) begin
                if (wait_cnt >= ack_wait) begin
                    mem_ack       = 1'b1;
                    wait_cnt      = 0;
                    last_mem_addr = mem_addr;
                    last_mem_we   = mem_we;
                    if (mem_we) begin
                        last_mem_wdata = mem_wdata;
                        mem_wr_n++;
                    end else begin
                        mem_rdata = memRead(mem_addr >> 2);
                        mem_rd_n++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Counts every handshake the controller accepts.
    int accept_n = 0;
    always @(posedge clk) begin
        if (!rst && cpu_req && cpu_ready) begin
            accept_n <= accept_n + 1;
        end
    end

    logic [CW-1:0] model_hits;
    logic [CW-1:0] model_misses;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic countLookup(input logic hit);
        if (hit) begin
            if (model_hits != {CW{1'b1}}) model_hits = model_hits + 1;
        end else begin
            if (model_misses != {CW{1'b1}}) model_misses = model_misses + 1;
        end
    endtask

    // Runs one CPU access from handshake to the cycle after completion and
    // checks latency, returned data, memory traffic, cache writes and stats.
    // With hold set, cpu_req stays high afterwards.
    task automatic applyStimulus(input logic we, input logic [DW-1:0] addr,
                                 input logic [DW-1:0] wdata, input int waits,
                                 input logic hold);
        logic          exp_hit;
        logic          exp_mem;
        int            exp_lat;
        int            exp_cwe;
        logic [DW-1:0] exp_data;
        logic [2:0]    idx;
        int            lat;
        int            to;
        int            cwe_n;
        int            req_rise;
        int            ready_bad;
        int            rd0;
        int            wr0;
        logic          prev_req;
        logic          seen;
        logic          cwe_with_done;
        logic [DW-1:0] cwe_data;
        logic [DW-1:0] lookup_addr;

        ack_wait = waits;
        to = 0;
        @(negedge clk);
        while (!cpu_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (!cpu_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end

        idx      = addr[4:2];
        exp_hit  = hit_mask && arr_valid[idx] && (arr_tag[idx] == (addr >> 5));
        exp_mem  = we || !exp_hit;
        exp_lat  = exp_mem ? 3 + waits : 2;
        exp_cwe  = (we ? exp_hit : !exp_hit) ? 1 : 0;
        exp_data = we ? wdata : memRead(addr >> 2);
        rd0 = mem_rd_n;
        wr0 = mem_wr_n;

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);

        lat = 0; cwe_n = 0; req_rise = 0; ready_bad = 0;
        prev_req = 1'b0; seen = 1'b0; cwe_with_done = 1'b0;
        cwe_data = '0; lookup_addr = '0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (!hold) cpu_req = 1'b0;
            if (lat == 1) lookup_addr = cache_addr;
            if (mem_req && !prev_req) req_rise++;
            prev_req = mem_req;
            if (cache_we) begin
                cwe_n++;
                cwe_with_done = cpu_done;
                cwe_data      = cache_wdata;
            end
            if (cpu_done) seen = 1'b1;
            else if (cpu_ready) ready_bad++;
        end
        if (!seen) begin
            cpu_req = 1'b0;
            checkOutput("done_timeout", 0, 1);
            return;
        end

        countLookup(exp_hit);
        checkOutput("latency", lat, exp_lat);
        checkOutput("cache_addr", lookup_addr, addr);
        checkOutput("ready_while_busy", ready_bad, 0);
        checkOutput("mem_req_rises", req_rise, exp_mem ? 1 : 0);
        checkOutput("mem_reads", mem_rd_n - rd0, (exp_mem && !we) ? 1 : 0);
        checkOutput("mem_writes", mem_wr_n - wr0, we ? 1 : 0);
        if (exp_mem) begin
            checkOutput("mem_addr", last_mem_addr, {addr[DW-1:2], 2'b00});
            checkOutput("mem_we", last_mem_we, we);
        end
        if (we) checkOutput("mem_wdata", last_mem_wdata, wdata);
        else    checkOutput("cpu_rdata", cpu_rdata, exp_data);
        checkOutput("cache_we_pulses", cwe_n, exp_cwe);
        if (exp_cwe == 1) begin
            checkOutput("cache_wdata", cwe_data, exp_data);
            checkOutput("cache_we_with_done", cwe_with_done, 1);
        end
        checkOutput("hit_count", hit_count, model_hits);
        checkOutput("miss_count", miss_count, model_misses);

        if (we) mem_model[addr >> 2] = wdata;

        @(negedge clk);
        checkOutput("done_width", cpu_done, 0);
        checkOutput("cache_we_width", cache_we, 0);
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            to;
        int            acc0;
        logic          rnd_we;
        logic [DW-1:0] rnd_addr;

        total = 0;
        bad   = 0;
        rst        = 1'b1;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        hit_mask   = 1'b1;
        arr_clear  = 1'b1;
        manual_ack = 1'b0;
        ack_wait   = 0;
        model_hits   = '0;
        model_misses = '0;

        repeat (3) @(negedge clk);
        rst       = 1'b0;
        arr_clear = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_ready", cpu_ready, 1);
        checkOutput("rst_done", cpu_done, 0);
        checkOutput("rst_rdata", cpu_rdata, 0);
        checkOutput("rst_cache_we", cache_we, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_hits", hit_count, 0);
        checkOutput("rst_misses", miss_count, 0);

        $display("[TB] load miss, load hit, store hit, store miss");
        mem_model[32'h4] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 2, 1'b0);
        checkOutput("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        checkOutput("t1_misses", miss_count, 1);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
        checkOutput("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
        checkOutput("t2_hits", hit_count, 1);
        applyStimulus(1'b1, 32'h0000_0013, 32'h1234_5678, 0, 1'b0);
        checkOutput("t3_mem_addr", last_mem_addr, 32'h0000_0010);
        hit_mask = 1'b0;
        applyStimulus(1'b1, 32'h0000_0013, 32'h1234_5678, 0, 1'b0);
        hit_mask = 1'b1;

        $display("[TB] request held through a read miss");
        acc0 = accept_n;
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 1, 1'b1);
        checkOutput("hold_accepts", accept_n - acc0, 1);
        checkOutput("hold_ready_after_done", cpu_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("hold_second_accept", accept_n - acc0, 2);
        @(negedge clk);
        cpu_req = 1'b0;
        countLookup(1'b1);
        to = 0;
        while (!cpu_done && to < 20) begin
            @(negedge clk);
            to++;
        end
        checkOutput("hold2_done", cpu_done, 1);
        checkOutput("hold2_latency", to + 1, 2);
        checkOutput("hold2_rdata", cpu_rdata, memRead(32'h0000_0030 >> 2));
        checkOutput("hold2_hits", hit_count, model_hits);
        checkOutput("hold_accepts_final", accept_n - acc0, 2);
        @(negedge clk);

        $display("[TB] reset during refill");
        ack_wait  = 20;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0050;
        cpu_wdata = '0;
        checkOutput("rf_ready", cpu_ready, 1);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("rf_mem_req", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hits   = '0;
        model_misses = '0;
        checkOutput("rf_mem_req_drop", mem_req, 0);
        checkOutput("rf_ready_after", cpu_ready, 1);
        checkOutput("rf_hits", hit_count, 0);
        checkOutput("rf_misses", miss_count, 0);
        checkOutput("rf_done", cpu_done, 0);
        checkOutput("rf_cache_we", cache_we, 0);
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        checkOutput("late_ack_done", cpu_done, 0);
        checkOutput("late_ack_cache_we", cache_we, 0);
        checkOutput("late_ack_ready", cpu_ready, 1);
        @(negedge clk);
        checkOutput("late_ack_done2", cpu_done, 0);
        checkOutput("late_ack_mem_req", mem_req, 0);
        checkOutput("late_ack_misses", miss_count, 0);

        $display("[TB] miss counter saturation");
        force dut.miss_count = {CW{1'b1}};
        @(negedge clk);
        release dut.miss_count;
        model_misses = {CW{1'b1}};
        checkOutput("sat_preload", miss_count, {CW{1'b1}});
        applyStimulus(1'b0, 32'h0000_0070, 32'h0, 0, 1'b0);
        checkOutput("sat_misses", miss_count, {CW{1'b1}});
        applyStimulus(1'b0, 32'h0000_0070, 32'h0, 1, 1'b0);
        checkOutput("sat_hits", hit_count, 1);

        $display("[TB] random accesses");
        for (int n = 0; n < 80; n++) begin
            rnd_we   = 1'($urandom_range(0, 1));
            rnd_addr = DW'($urandom_range(0, 3) << 5) |
                       DW'($urandom_range(0, 7) << 2) |
                       DW'($urandom_range(0, 3));
            applyStimulus(rnd_we, rnd_addr, DW'($urandom), $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
